uart_frame_rx: RTL and testbench

- Receive-side framer between the UART byte receiver and the game-state registers.
- Consumes the receiver's one-cycle byte strobe and data byte, hunts for a sync byte, and collects a fixed-length payload plus checksum.
- Publishes the payload to the game logic only after the checksum passes.
- Flags bad checksums and stalled frames so that corrupted link traffic never moves the enemy tank, bullet or HP state.

---
 rtl/uart_frame_rx_if.sv | 26 ++
 rtl/uart_frame_rx.sv | 134 +++++++++++++
 tb/tb_uart_frame_rx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_frame_rx_if.sv
// Link between the UART byte receiver, the frame receiver and the game registers.
// Carries the byte strobe/data in and the validated payload plus status out.
interface uart_frame_rx_if #(
    parameter int PAYLOAD_BYTES = 8
);
    logic                       rx_done_tick;
    logic [7:0]                 rx_data;
    logic [8*PAYLOAD_BYTES-1:0] payload_out;
    logic                       frame_valid;
    logic                       chk_err;
    logic                       timeout_err;
    logic [7:0]                 err_count;
    logic                       busy;

    modport master (
        output rx_done_tick, rx_data,
        input  payload_out, frame_valid, chk_err,
        input  timeout_err, err_count, busy
    );

    modport slave (
        input  rx_done_tick, rx_data,
        output payload_out, frame_valid, chk_err,
        output timeout_err, err_count, busy
    );
endinterface

// File: rtl/uart_frame_rx.sv
// Framer: hunts for SYNC_BYTE, collects PAYLOAD_BYTES plus checksum, publishes on match.
// Ports: clk, reset (sync, active high), bus (slave: byte in, payload/status out).
module uart_frame_rx #(
    parameter int         PAYLOAD_BYTES  = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65536,
    parameter int         TO_BIT         = 17
) (
    input logic            clk,
    input logic            reset,
    uart_frame_rx_if.slave bus
);
    localparam int PW = 8 * PAYLOAD_BYTES;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [TO_BIT-1:0] timer_q, timer_d;
    logic [PW-1:0]     shadow_q, shadow_d;
    logic [PW-1:0]     payload_q, payload_d;
    logic [7:0]        err_q, err_d;
    logic              fv_q, fv_d;
    logic              ce_q, ce_d;
    logic              te_q, te_d;
    logic              err_inc;
    logic              expired;

    // A byte in the expiry cycle wins: expiry is only consulted without a tick.
    assign expired = (timer_q == TO_BIT'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HUNT;
            idx_q     <= '0;
            sum_q     <= '0;
            timer_q   <= '0;
            shadow_q  <= '0;
            payload_q <= '0;
            err_q     <= '0;
            fv_q      <= 1'b0;
            ce_q      <= 1'b0;
            te_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            timer_q   <= timer_d;
            shadow_q  <= shadow_d;
            payload_q <= payload_d;
            err_q     <= err_d;
            fv_q      <= fv_d;
            ce_q      <= ce_d;
            te_q      <= te_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        timer_d   = timer_q;
        shadow_d  = shadow_q;
        payload_d = payload_q;
        fv_d      = 1'b0;
        ce_d      = 1'b0;
        te_d      = 1'b0;
        err_inc   = 1'b0;

        unique case (state_q)
            HUNT: begin
                timer_d = '0;
                if (bus.rx_done_tick && bus.rx_data == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            PAYLOAD: begin
                if (bus.rx_done_tick) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
                    sum_d   = sum_q + bus.rx_data;
                    idx_d   = idx_q + 5'd1;
                    timer_d = '0;
                    if (idx_q == 5'(PAYLOAD_BYTES - 1))
                        state_d = CHECK;
                end else if (expired) begin
                    state_d = HUNT;
                    timer_d = '0;
                    te_d    = 1'b1;
                    err_inc = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                if (bus.rx_done_tick) begin
                    state_d = HUNT;
                    timer_d = '0;
                    if (bus.rx_data == sum_q) begin
                        payload_d = shadow_q;
                        fv_d      = 1'b1;
                    end else begin
                        ce_d    = 1'b1;
                        err_inc = 1'b1;
                    end
                end else if (expired) begin
                    state_d = HUNT;
                    timer_d = '0;
                    te_d    = 1'b1;
                    err_inc = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        // Saturate rather than wrap so a flood of errors stays visible.
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    assign bus.payload_out = payload_q;
    assign bus.frame_valid = fv_q;
    assign bus.chk_err     = ce_q;
    assign bus.timeout_err = te_q;
    assign bus.err_count   = err_q;
    assign bus.busy        = (state_q != HUNT);
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a short timeout to keep runs small.
// Ports: none; drives the interface master side and checks status/payload.
module tb_uart_frame_rx;
    localparam int TO  = 200;
    localparam int TOB = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    uart_frame_rx_if #(.PAYLOAD_BYTES(8)) bus ();

    uart_frame_rx #(
        .PAYLOAD_BYTES (8),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO),
        .TO_BIT        (TOB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; the byte is captured at the next edge.
    task automatic send(input logic [7:0] b);
        bus.rx_done_tick = 1'b1;
        bus.rx_data      = b;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [63:0] p, input logic [7:0] ck);
        send(8'hA5);
        for (int k = 0; k < 8; k++) send(p[8*k +: 8]);
        send(ck);
    endtask

    localparam logic [63:0] P1 = 64'h0807060504030201;
    localparam logic [63:0] PA = {8{8'hA5}};
    localparam logic [63:0] P2 = 64'h8877665544332211;

    initial begin
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        reset            = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_payload", bus.payload_out, 64'h0);
        check("rst_err", 64'(bus.err_count), 64'h0);
        check("rst_flags", {bus.frame_valid, bus.chk_err,
                            bus.timeout_err, bus.busy}, 4'b0000);

        frame(P1, 8'h24);
        check("good_fv", {bus.frame_valid, bus.chk_err, bus.timeout_err}, 3'b100);
        check("good_payload", bus.payload_out, P1);
        check("good_err", 64'(bus.err_count), 64'h0);
        idle(1);
        check("good_fv_width", 64'(bus.frame_valid), 64'h0);

        frame(P1 ^ 64'h0000000000000300, 8'h25);
        check("bad_ce", {bus.frame_valid, bus.chk_err, bus.timeout_err}, 3'b010);
        check("bad_payload", bus.payload_out, P1);
        check("bad_err", 64'(bus.err_count), 64'h1);
        check("bad_busy", 64'(bus.busy), 64'h0);
        idle(1);
        check("bad_ce_width", 64'(bus.chk_err), 64'h0);

        send(8'h00);
        send(8'h3C);
        check("hunt_quiet", {bus.chk_err, bus.timeout_err, bus.busy}, 3'b000);
        frame(PA, 8'h28);
        check("sync_data_fv", 64'(bus.frame_valid), 64'h1);
        check("sync_data_payload", bus.payload_out, PA);
        check("sync_data_err", 64'(bus.err_count), 64'h1);

        send(8'hA5);
        send(8'h01);
        send(8'h02);
        idle(TO - 1);
        check("to_before", {bus.timeout_err, bus.busy}, 2'b01);
        idle(1);
        check("to_pulse", {bus.timeout_err, bus.busy}, 2'b10);
        check("to_err", 64'(bus.err_count), 64'h2);
        check("to_payload", bus.payload_out, PA);
        idle(1);
        check("to_width", 64'(bus.timeout_err), 64'h0);
        frame(P1, 8'h24);
        check("to_after_fv", 64'(bus.frame_valid), 64'h1);
        check("to_after_payload", bus.payload_out, P1);

        send(8'hA5);
        send(8'h01);
        idle(TO - 1);
        send(8'h02);
        check("race_no_to", {bus.timeout_err, bus.busy}, 2'b01);
        for (int k = 2; k < 8; k++) send(P2[8*k +: 8] & 8'h00 | 8'(k + 1));
        send(8'h24);
        check("race_fv", {bus.frame_valid, bus.timeout_err}, 2'b10);
        check("race_err", 64'(bus.err_count), 64'h2);

        frame(P1, 8'h24);
        frame(P2, 8'h64);
        check("b2b_fv", 64'(bus.frame_valid), 64'h1);
        check("b2b_payload", bus.payload_out, P2);

        send(8'hA5);
        for (int k = 1; k <= 4; k++) send(8'(k));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_payload", bus.payload_out, 64'h0);
        check("mid_rst_flags", {bus.frame_valid, bus.chk_err, bus.timeout_err,
                                bus.busy, bus.err_count}, 12'h000);
        frame(P1, 8'h24);
        check("post_rst_fv", 64'(bus.frame_valid), 64'h1);
        check("post_rst_payload", bus.payload_out, P1);

        for (int n = 0; n < 300; n++) frame(P2, 8'h00);
        check("sat_err", 64'(bus.err_count), 64'hFF);
        check("sat_payload", bus.payload_out, P1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
